// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: FSM state encoding and
// the default debounce length.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    // 10 ms of stable level at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;

endpackage

// File: rtl/key_debounce.sv
// One key path: 2-flop synchronizer, stability counter and accepted level,
// producing a single-cycle pulse when the accepted level goes from released to pressed.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam logic [DB_W-1:0] LAST_CNT = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [DB_W-1:0] cnt_q,   cnt_d;
    logic            press_q, press_d;

    // Synchronizer, debounce counter, accepted level and press pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounced start/stop and lap/reset keys drive the
// run/lap/pause/idle FSM, the counter enable/clear and the held display value.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_W            = 20,
    parameter int DATA_W          = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              key_ss_n,
    input  logic              key_lr_n,
    input  logic [DATA_W-1:0] count_in,
    output logic              count_en,
    output logic              count_clr,
    output logic [DATA_W-1:0] disp_out,
    output logic [1:0]        state
);

    logic ss_ev_s;
    logic lr_ev_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_ss (
        .clock  (clock),
        .reset_n(reset_n),
        .key_n  (key_ss_n),
        .press  (ss_ev_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lr (
        .clock  (clock),
        .reset_n(reset_n),
        .key_n  (key_lr_n),
        .press  (lr_ev_s)
    );

    sw_state_e         state_q, state_d;
    logic              en_q,    en_d;
    logic              clr_q,   clr_d;
    logic [DATA_W-1:0] lap_q,   lap_d;
    logic [DATA_W-1:0] disp_q,  disp_d;

    // FSM state, output and lap/display registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            lap_q   <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
        end
    end

    // Next state; start/stop takes priority over a coincident lap/reset event.
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_ev_s) begin
                    state_d = RUN;
                end else if (lr_ev_s) begin
                    clr_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (ss_ev_s) begin
                    state_d = PAUSE;
                end else if (lr_ev_s) begin
                    state_d = LAP;
                    lap_d   = count_in;
                end else begin
                    state_d = RUN;
                end
            end
            LAP: begin
                if (ss_ev_s) begin
                    state_d = PAUSE;
                end else if (lr_ev_s) begin
                    state_d = RUN;
                end else begin
                    state_d = LAP;
                end
            end
            PAUSE: begin
                if (ss_ev_s) begin
                    state_d = RUN;
                end else if (lr_ev_s) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs follow the next state so they line up with the registered state.
        en_d   = (state_d == RUN) || (state_d == LAP);
        disp_d = (state_d == LAP) ? lap_d : count_in;
    end

    assign state     = state_q;
    assign count_en  = en_q;
    assign count_clr = clr_q;
    assign disp_out  = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a short debounce length; display
// values are predicted into a scoreboard queue before each edge and checked after it.
module tb_stopwatch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        key_ss_n;
    logic        key_lr_n;
    logic [23:0] count_in;
    logic        count_en;
    logic        count_clr;
    logic [23:0] disp_out;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];
    bit          sb_en    = 1'b0;
    bit          ramp     = 1'b0;
    bit          lap_mode = 1'b0;
    logic [23:0] lap_val  = 24'h0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .DB_W(3), .DATA_W(24)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .key_ss_n (key_ss_n),
        .key_lr_n (key_lr_n),
        .count_in (count_in),
        .count_en (count_en),
        .count_clr(count_clr),
        .disp_out (disp_out),
        .state    (state)
    );

    always #5 clock = ~clock;

    // One clock: predict disp_out, take the edge, compare, then advance the ramp.
    task automatic step();
        logic [23:0] e;
        if (sb_en) exp_q.push_back(lap_mode ? lap_val : count_in);
        @(posedge clock);
        #1;
        if (sb_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp_out !== e) begin
                failures++;
                $display("FAIL disp_track: got %h expected %h", disp_out, e);
            end
        end
        if (ramp) count_in = count_in + 24'd1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        @(posedge clock);
        #3;
        reset_n  = 1'b0;
        key_ss_n = 1'($urandom_range(0, 1));
        key_lr_n = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if ({state, count_en, count_clr, disp_out} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs: got state=%0d en=%b clr=%b disp=%h expected all 0",
                     state, count_en, count_clr, disp_out);
        end
        #10;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (state !== 2'd0 || count_en !== 1'b0 || count_clr !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_event: cycle %0d got state=%0d en=%b clr=%b expected 0/0/0",
                         i, state, count_en, count_clr);
            end
        end
        key_ss_n = 1'b1;
        key_lr_n = 1'b1;
        reset_n  = 1'b0;
        steps(2);
        reset_n  = 1'b1;
        steps(2);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 30; i++) begin
            key_ss_n = (i < 20) ? (((i / 2) % 2) != 0) : 1'b1;
            step();
            checks++;
            if (state !== 2'd0 || count_en !== 1'b0) begin
                failures++;
                $display("FAIL bounce_reject: cycle %0d got state=%0d en=%b expected 0/0", i, state, count_en);
            end
        end
    endtask

    task automatic test_clean_start();
        key_ss_n = 1'b0;
        steps(6);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL start_early: got state=%0d expected 0 after 6 edges", state);
        end
        step();
        checks++;
        if (state !== 2'd1 || count_en !== 1'b1) begin
            failures++;
            $display("FAIL start_run: got state=%0d en=%b expected 1/1 after 7 edges", state, count_en);
        end
        steps(50);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL start_hold: got state=%0d expected 1", state);
        end
        key_ss_n = 1'b1;
        steps(10);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL start_release: got state=%0d expected 1", state);
        end
    endtask

    task automatic test_lap_freeze();
        ramp     = 1'b1;
        count_in = 24'h000123 - 24'd6;
        lap_val  = 24'h000123;
        key_lr_n = 1'b0;
        steps(6);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL lap_early: got state=%0d expected 1", state);
        end
        step();
        lap_mode = 1'b1;
        checks++;
        if (state !== 2'd3 || count_en !== 1'b1 || disp_out !== 24'h000123) begin
            failures++;
            $display("FAIL lap_enter: got state=%0d en=%b disp=%h expected 3/1/000123",
                     state, count_en, disp_out);
        end
        key_lr_n = 1'b1;
        steps(12);
        checks++;
        if (state !== 2'd3 || count_en !== 1'b1) begin
            failures++;
            $display("FAIL lap_hold: got state=%0d en=%b expected 3/1", state, count_en);
        end
        key_lr_n = 1'b0;
        steps(6);
        lap_mode = 1'b0;
        step();
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL lap_exit: got state=%0d expected 1", state);
        end
        steps(5);
        key_lr_n = 1'b1;
        steps(10);
    endtask

    task automatic test_pause_clear();
        key_ss_n = 1'b0;
        steps(7);
        checks++;
        if (state !== 2'd2 || count_en !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter: got state=%0d en=%b expected 2/0", state, count_en);
        end
        key_ss_n = 1'b1;
        steps(10);
        key_lr_n = 1'b0;
        steps(6);
        checks++;
        if (state !== 2'd2 || count_clr !== 1'b0) begin
            failures++;
            $display("FAIL clear_early: got state=%0d clr=%b expected 2/0", state, count_clr);
        end
        step();
        checks++;
        if (state !== 2'd0 || count_clr !== 1'b1) begin
            failures++;
            $display("FAIL clear_pulse: got state=%0d clr=%b expected 0/1", state, count_clr);
        end
        step();
        checks++;
        if (count_clr !== 1'b0) begin
            failures++;
            $display("FAIL clear_width: got clr=%b expected 0", count_clr);
        end
        key_lr_n = 1'b1;
        steps(10);
    endtask

    task automatic test_simultaneous();
        key_ss_n = 1'b0;
        steps(7);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL simul_setup: got state=%0d expected 1", state);
        end
        key_ss_n = 1'b1;
        steps(10);
        key_ss_n = 1'b0;
        key_lr_n = 1'b0;
        steps(7);
        checks++;
        if (state !== 2'd2 || count_clr !== 1'b0 || count_en !== 1'b0) begin
            failures++;
            $display("FAIL simul_priority: got state=%0d clr=%b en=%b expected 2/0/0",
                     state, count_clr, count_en);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (state !== 2'd2 || count_clr !== 1'b0) begin
                failures++;
                $display("FAIL simul_after: cycle %0d got state=%0d clr=%b expected 2/0", i, state, count_clr);
            end
        end
        key_ss_n = 1'b1;
        key_lr_n = 1'b1;
        steps(10);
    endtask

    initial begin
        reset_n  = 1'b0;
        key_ss_n = 1'b1;
        key_lr_n = 1'b1;
        count_in = 24'h0;
        test_reset();
        sb_en = 1'b1;
        test_bounce();
        test_clean_start();
        test_lap_freeze();
        test_pause_clear();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
